// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM channel.
//   - pwm_state_e : dead-time FSM state encoding (3-bit binary)
//   - DT_WIDTH_DEFAULT / WIDTH_DEFAULT : default parameter widths
package pwm_pkg;

  localparam int unsigned WIDTH_DEFAULT    = 8;
  localparam int unsigned DT_WIDTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_A_ON   = 3'd1,
    ST_DEAD_A = 3'd2,
    ST_B_ON   = 3'd3,
    ST_DEAD_B = 3'd4
  } pwm_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns the raw compare bit into two complementary outputs
// separated by a programmable dead time.
//   clk, rst_n  : clock, async active-low reset
//   enable      : low forces OFF and clears the dead-time counter
//   raw         : compare result from the channel
//   deadtime    : dead-time length, sampled when the down-counter loads
//   pwm_out     : primary output (registered, high only in A_ON)
//   pwm_out_n   : complementary output (registered, high only in B_ON)
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                raw,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                pwm_out,
  output logic                pwm_out_n
);

  pwm_state_e          state;
  logic [DT_WIDTH-1:0] dt_cnt;

  // Outputs are registered alongside the state so each one is high only
  // in its own ON state; the two can never be high together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      dt_cnt    <= '0;
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
      if (!enable) begin
        state  <= ST_OFF;
        dt_cnt <= '0;
      end else begin
        case (state)
          ST_OFF: begin
            dt_cnt <= deadtime;
            state  <= raw ? ST_DEAD_A : ST_DEAD_B;
          end
          // Expiry takes priority over a reversal seen in the same cycle.
          ST_DEAD_A: begin
            if (dt_cnt == '0) begin
              state   <= ST_A_ON;
              pwm_out <= 1'b1;
            end else if (!raw) begin
              state  <= ST_DEAD_B;
              dt_cnt <= deadtime;
            end else begin
              dt_cnt <= dt_cnt - DT_WIDTH'(1);
            end
          end
          ST_DEAD_B: begin
            if (dt_cnt == '0) begin
              state     <= ST_B_ON;
              pwm_out_n <= 1'b1;
            end else if (raw) begin
              state  <= ST_DEAD_A;
              dt_cnt <= deadtime;
            end else begin
              dt_cnt <= dt_cnt - DT_WIDTH'(1);
            end
          end
          ST_A_ON: begin
            if (!raw) begin
              state  <= ST_DEAD_B;
              dt_cnt <= deadtime;
            end else begin
              pwm_out <= 1'b1;
            end
          end
          ST_B_ON: begin
            if (raw) begin
              state  <= ST_DEAD_A;
              dt_cnt <= deadtime;
            end else begin
              pwm_out_n <= 1'b1;
            end
          end
          default: begin
            state  <= ST_OFF;
            dt_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel driven by a shared up-counting timebase.
//   clk, rst_n    : clock, async active-low reset
//   enable        : channel enable; low forces both outputs low
//   counter_value : timebase value, 0..period_top
//   period_top    : last count of the period
//   duty_wr       : one-cycle write strobe for duty_data
//   duty_data     : new duty (high counts per period)
//   deadtime      : dead-time length in clk cycles
//   invert        : duty defines low time instead of high time
//   pwm_out       : primary output
//   pwm_out_n     : complementary output
//   period_start  : one-cycle pulse the cycle after each boundary
//   duty_pending  : a written duty waits for the next boundary
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEFAULT,
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [WIDTH-1:0]    counter_value,
  input  logic [WIDTH-1:0]    period_top,
  input  logic                duty_wr,
  input  logic [WIDTH-1:0]    duty_data,
  input  logic [DT_WIDTH-1:0] deadtime,
  input  logic                invert,
  output logic                pwm_out,
  output logic                pwm_out_n,
  output logic                period_start,
  output logic                duty_pending
);

  logic [WIDTH-1:0] active_duty;
  logic [WIDTH-1:0] pending_duty;
  logic             boundary_c;
  logic             raw_c;

  assign boundary_c = enable && (counter_value == period_top);
  assign raw_c      = (counter_value < active_duty) ^ invert;

  // Double-buffered duty: a write coinciding with a boundary bypasses the
  // pending register; otherwise the latest write waits for the boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_duty  <= '0;
      pending_duty <= '0;
      duty_pending <= 1'b0;
    end else if (duty_wr && boundary_c) begin
      active_duty  <= duty_data;
      pending_duty <= duty_data;
      duty_pending <= 1'b0;
    end else if (duty_wr) begin
      pending_duty <= duty_data;
      duty_pending <= 1'b1;
    end else if (boundary_c && duty_pending) begin
      active_duty  <= pending_duty;
      duty_pending <= 1'b0;
    end
  end

  // Period boundary pulse, delayed one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= boundary_c;
    end
  end

  pwm_deadtime #(
    .DT_WIDTH (DT_WIDTH)
  ) u_deadtime (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .raw       (raw_c),
    .deadtime  (deadtime),
    .pwm_out   (pwm_out),
    .pwm_out_n (pwm_out_n)
  );

endmodule

// File: tb/tb_pwm_channel.sv
module tb_pwm_channel;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] counter_value;
  logic [7:0] period_top;
  logic       duty_wr;
  logic [7:0] duty_data;
  logic [3:0] deadtime;
  logic       invert;
  logic       pwm_out;
  logic       pwm_out_n;
  logic       period_start;
  logic       duty_pending;

  int vectors;
  int miscompares;
  int cval;

  localparam int PTOP = 9;

  pwm_channel #(.WIDTH(8), .DT_WIDTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .counter_value (counter_value),
    .period_top    (period_top),
    .duty_wr       (duty_wr),
    .duty_data     (duty_data),
    .deadtime      (deadtime),
    .invert        (invert),
    .pwm_out       (pwm_out),
    .pwm_out_n     (pwm_out_n),
    .period_start  (period_start),
    .duty_pending  (duty_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] duty;
    logic [3:0] dt;
    logic       inv;
    int         exp_a;
    int         exp_b;
    int         exp_low;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: the edge samples current inputs, then the timebase advances.
  task automatic tick();
    @(posedge clk);
    #1;
    cval          = (cval >= PTOP) ? 0 : cval + 1;
    counter_value = 8'(cval);
    duty_wr       = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_duty(input logic [7:0] d);
    duty_data = d;
    duty_wr   = 1'b1;
    tick();
  endtask

  task automatic wait_cval(input int target);
    for (int i = 0; i < 20 && cval != target; i++) tick();
    check("reach_cval", cval, target);
  endtask

  // Count output levels over one full 10-cycle period.
  task automatic measure(output int a, output int b, output int low,
                         output int ps, output int pend);
    a = 0; b = 0; low = 0; ps = 0; pend = 0;
    for (int i = 0; i < PTOP + 1; i++) begin
      tick();
      a    += int'(pwm_out);
      b    += int'(pwm_out_n);
      low  += int'(!pwm_out && !pwm_out_n);
      ps   += int'(period_start);
      pend += int'(duty_pending);
    end
  endtask

  // Overlap monitor
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (pwm_out && pwm_out_n) begin
        miscompares++;
        $display("FAIL overlap: pwm_out=%0b pwm_out_n=%0b required not both 1",
                 pwm_out, pwm_out_n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int a, b, low, ps, pend, cnt;

    vecs[0] = '{8'd3,  4'd0,  1'b0, 2, 6, 2};
    vecs[1] = '{8'd3,  4'd2,  1'b0, 1, 3, 6};
    vecs[2] = '{8'd0,  4'd0,  1'b0, 0, 10, 0};
    vecs[3] = '{8'd10, 4'd0,  1'b0, 10, 0, 0};
    vecs[4] = '{8'd3,  4'd0,  1'b1, 6, 2, 2};
    vecs[5] = '{8'd5,  4'd1,  1'b0, 3, 3, 4};
    vecs[6] = '{8'd8,  4'd3,  1'b0, 4, 0, 6};
    vecs[7] = '{8'd3,  4'd15, 1'b0, 0, 0, 10};

    vectors = 0; miscompares = 0;
    cval = 0;
    rst_n = 1'b0; enable = 1'b1; counter_value = 8'd0; period_top = 8'(PTOP);
    duty_wr = 1'b0; duty_data = 8'd0; deadtime = 4'd0; invert = 1'b0;

    #3;
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_pwm_out_n", int'(pwm_out_n), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_duty_pending", int'(duty_pending), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Steady-state table
    foreach (vecs[k]) begin
      deadtime = vecs[k].dt;
      invert   = vecs[k].inv;
      set_duty(vecs[k].duty);
      ticks(30);
      measure(a, b, low, ps, pend);
      check($sformatf("v%0d_a_high", k), a, vecs[k].exp_a);
      check($sformatf("v%0d_b_high", k), b, vecs[k].exp_b);
      check($sformatf("v%0d_both_low", k), low, vecs[k].exp_low);
      check($sformatf("v%0d_period_start", k), ps, 1);
    end

    // Double buffering: write 7 mid-period
    deadtime = 4'd0; invert = 1'b0;
    set_duty(8'd3);
    ticks(30);
    wait_cval(4);
    set_duty(8'd7);
    check("db_pending_set", int'(duty_pending), 1);
    cnt = 0; pend = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt  += int'(pwm_out_n);
      pend += int'(duty_pending);
    end
    tick();
    cnt += int'(pwm_out_n);
    check("db_old_duty_held", cnt, 5);
    check("db_pending_held", pend, 4);
    check("db_pending_clear", int'(duty_pending), 0);
    check("db_period_start", int'(period_start), 1);
    measure(a, b, low, ps, pend);
    check("db_new_a_high", a, 6);
    check("db_new_b_high", b, 2);

    // Write exactly at the boundary
    wait_cval(9);
    set_duty(8'd5);
    check("bw_pending_clear", int'(duty_pending), 0);
    measure(a, b, low, ps, pend);
    check("bw_a_high", a, 4);
    check("bw_b_high", b, 4);
    check("bw_pending_never", pend, 0);

    // Two writes in one period: the last wins
    wait_cval(2);
    set_duty(8'd2);
    wait_cval(5);
    set_duty(8'd8);
    check("lw_pending_set", int'(duty_pending), 1);
    tick();
    wait_cval(0);
    check("lw_pending_clear", int'(duty_pending), 0);
    measure(a, b, low, ps, pend);
    check("lw_a_high", a, 7);
    check("lw_b_high", b, 1);

    // Asynchronous reset while A_ON with a pending write
    wait_cval(1);
    set_duty(8'd4);
    check("ar_in_a_on", int'(pwm_out), 1);
    check("ar_pending_before", int'(duty_pending), 1);
    rst_n = 1'b0;
    #1;
    check("ar_pwm_out", int'(pwm_out), 0);
    check("ar_pwm_out_n", int'(pwm_out_n), 0);
    check("ar_duty_pending", int'(duty_pending), 0);
    check("ar_period_start", int'(period_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_dead_after_release", int'(pwm_out || pwm_out_n), 0);
    tick();
    check("ar_b_on_after_release", int'(pwm_out_n), 1);
    measure(a, b, low, ps, pend);
    check("ar_duty0_a_high", a, 0);
    check("ar_duty0_b_high", b, 10);
    check("ar_pending_after", pend, 0);

    // Enable low, then re-enable with raw = 1
    enable = 1'b0;
    tick();
    check("en_low_outputs", int'(pwm_out || pwm_out_n), 0);
    set_duty(8'd0);
    measure(a, b, low, ps, pend);
    check("en_low_both_low", low, 10);
    check("en_low_period_start", ps, 0);
    check("en_low_pending_kept", int'(duty_pending), 1);
    invert = 1'b1; deadtime = 4'd2;
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt += int'(pwm_out);
    end
    check("en_dead_low", cnt, 0);
    tick();
    check("en_rise", int'(pwm_out), 1);
    tick();
    wait_cval(0);
    check("en_pending_consumed", int'(duty_pending), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_channel.md
# pwm_channel

Single PWM channel that consumes the free-running value produced by the shared `Counter` timebase and turns it into a pair of complementary, dead-time-separated outputs. Duty updates are double-buffered and take effect only at a period boundary, so outputs never glitch mid-period. Several channels sit side by side on one counter to form a multi-phase PWM peripheral.

## Interface
- `WIDTH`, 8: width of counter value, period top and duty.
- `DT_WIDTH`, 4: width of the dead-time count.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  channel enable; low forces both outputs low.
- `counter_value`  in  WIDTH  current timebase value, counting up from 0 to `period_top`.
- `period_top`  in  WIDTH  last value of the period, equal to the counter's TOP.
- `duty_wr`  in  1  single-cycle write strobe for `duty_data`.
- `duty_data`  in  WIDTH  new duty, in counts of high time per period.
- `deadtime`  in  DT_WIDTH  dead-time length in clk cycles.
- `invert`  in  1  inverts the compare result, so duty defines low time instead of high time.
- `pwm_out`  out  1  primary output.
- `pwm_out_n`  out  1  complementary output.
- `period_start`  out  1  one-cycle pulse at each period boundary.
- `duty_pending`  out  1  a written duty is waiting for the next boundary.

## Operation
- **Boundary:** a cycle with `counter_value == period_top` and `enable` high.
- **Duty buffering:**
  - `duty_wr` stores `duty_data` in `pending_duty` and sets `duty_pending`.
  - At a boundary with `duty_pending` set, `active_duty` takes `pending_duty` and `duty_pending` clears.
  - If `duty_wr` and a boundary occur in the same cycle, `duty_data` goes straight to `active_duty` and `duty_pending` stays clear.
  - The last write before a boundary wins.
- **Compare:**
  - `raw = (counter_value < active_duty) ^ invert`.
  - `active_duty = 0` gives 0% duty.
  - `active_duty > period_top` gives 100% duty.
  - The compare is unsigned and WIDTH bits wide, with no overflow handling.
- **Dead-time FSM** (states OFF, A_ON, DEAD_A, B_ON, DEAD_B):
  - OFF: both outputs low. Next state is DEAD_A if `raw`, else DEAD_B.
  - DEAD_A / DEAD_B: both outputs low. A down-counter is loaded with `deadtime` on entry.
    - When the counter reaches 0, go to A_ON / B_ON.
    - If `raw` reverses during dead time, move directly to the opposite dead state and reload the counter.
  - A_ON: `pwm_out` = 1. Go to DEAD_B when `raw` is 0.
  - B_ON: `pwm_out_n` = 1. Go to DEAD_A when `raw` is 1.
  - `deadtime = 0`: the dead states last one cycle with both outputs low.
  - `deadtime` is sampled only when the down-counter loads.
- **Enable low:** next state is OFF, the down-counter clears, `period_start` is 0, and pending and active duty are retained.
- **Overlap rule:** `pwm_out` and `pwm_out_n` are never high in the same cycle, under any input.

## Timing
- **Reset values:** `pwm_out` = 0, `pwm_out_n` = 0, `period_start` = 0, `duty_pending` = 0, `active_duty` = 0, `pending_duty` = 0, state = OFF.
- **Output registering:** all outputs are registered and driven directly from state.
- **Edge timing:** for a change of `raw` in cycle n, the departing output falls at n+1 and the arriving output rises at n+2+`deadtime`.
- **`period_start`:** high for exactly the one cycle after a boundary cycle.
- **`duty_pending`:** rises the cycle after `duty_wr` and falls the cycle after the boundary that consumes it.
- **Reset during operation:** outputs go low immediately (asynchronously); the FSM leaves OFF on the first clk edge after `rst_n` deasserts.

## Structure
- Package `pwm_pkg` holds the FSM state encoding (3-bit, one-hot not required) and the `DT_WIDTH` default.
- Sub-module `pwm_deadtime` holds the FSM plus the dead-time down-counter.
  - Inputs: `raw`, `enable`, `deadtime`.
  - Outputs: the two output bits.
- The top level holds duty buffering, the compare, and boundary and `period_start` logic.

## Test plan
- **Steady duty:** WIDTH = 8, `period_top` = 9, duty 3, `deadtime` = 0, invert 0.
  - `pwm_out` high 2 cycles per 10-cycle period.
  - `pwm_out_n` high 6 cycles per period.
  - 2 single-cycle gaps per period.
  - `period_start` every 10 cycles.
- **Dead time:** `deadtime` = 2, same setup.
  - Each edge has a 3-cycle both-low gap.
  - `pwm_out` high 1 cycle per period.
  - The overlap assertion never fires.
- **Double buffering:** write duty 7 while counter = 4.
  - Output unchanged until the counter wraps.
  - `duty_pending` = 1 until the cycle after counter = 9.
  - Next period uses duty 7.
- **Write at boundary, then a second write:** write duty 5 exactly when counter = 9.
  - Duty 5 is in effect in the following period, with `duty_pending` never set.
  - Then write 2 and then 8 in the same period: only 8 takes effect at the next boundary.
- **Extremes:** duty 0 holds `pwm_out` = 0 for a full period; duty 10 holds `pwm_out_n` = 0 for a full period; `invert` = 1 with duty 3 swaps the high-time lengths.
- **Reset and enable:**
  - `rst_n` low mid-A_ON: outputs 0 without a clock edge; all registers at reset values.
  - `enable` low: both outputs low the next cycle.
  - `enable` back high with `raw` = 1: `pwm_out` rises after `deadtime` + 1 cycles.
